// File: rtl/tama_pkg.sv
// Shared definitions for the care-action path: action bit indices, menu states
// and small helpers reused by the controller and the downstream stats block.
package tama_pkg;

    localparam logic [2:0] ACT_FEED       = 3'd0;
    localparam logic [2:0] ACT_PLAY_HAPPY = 3'd1;
    localparam logic [2:0] ACT_HEAL       = 3'd2;
    localparam logic [2:0] ACT_CLEAN      = 3'd3;
    localparam logic [2:0] ACT_PLAY       = 3'd4;
    localparam logic [2:0] ACT_SOCIAL     = 3'd5;
    localparam int         NUM_ACTIONS    = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    function automatic logic [7:0] action_onehot(input logic [2:0] idx);
        logic [7:0] vec;
        vec = 8'd0;
        if (idx < 3'(NUM_ACTIONS)) begin
            vec[idx] = 1'b1;
        end else begin
            vec = 8'd0;
        end
        return vec;
    endfunction

    function automatic logic [2:0] next_action(input logic [2:0] idx);
        logic [2:0] nxt;
        if (idx >= 3'(NUM_ACTIONS - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and a single-cycle
// pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, then flip the level only after an unbroken run of differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/action_controller.sv
// Menu front end for the stats block: debounced buttons drive a browse/confirm
// FSM that emits one-cycle one-hot action pulses, guarded by an energy check.
module action_controller
    import tama_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 64,
    parameter int IDLE_TIMEOUT    = 4096,
    parameter int PLAY_ENERGY_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic [3:0] energy,
    output logic [7:0] actions,
    output logic [2:0] menu_sel,
    output logic       menu_open,
    output logic       busy,
    output logic       reject
);

    localparam int            CD_W    = $clog2(COOLDOWN_CYCLES + 1);
    localparam int            TO_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

    logic            next_press_s, ok_press_s, back_press_s;
    logic            ev_next_s, ev_ok_s, ev_back_s, any_press_s, ok_allowed_s;
    state_t          state_r, state_next_s;
    logic [2:0]      menu_sel_r, sel_next_s;
    logic [CD_W-1:0] cd_cnt_r, cd_next_s;
    logic [TO_W-1:0] to_cnt_r, to_next_s;
    logic            reject_next_s;
    logic [7:0]      actions_r;
    logic            menu_open_r, busy_r, reject_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .reset(reset), .btn_raw(btn_next), .press(next_press_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
        .clk(clk), .reset(reset), .btn_raw(btn_ok), .press(ok_press_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clk(clk), .reset(reset), .btn_raw(btn_back), .press(back_press_s));

    // Simultaneous events: back wins over ok, ok over next; the losers are dropped.
    assign ev_back_s    = back_press_s;
    assign ev_ok_s      = ok_press_s & ~back_press_s;
    assign ev_next_s    = next_press_s & ~ok_press_s & ~back_press_s;
    assign any_press_s  = next_press_s | ok_press_s | back_press_s;
    assign ok_allowed_s = !((menu_sel_r == ACT_PLAY) && (energy < 4'(PLAY_ENERGY_MIN)));

    // Next-state, selection, counters and reject decision.
    always_comb begin
        state_next_s  = state_r;
        sel_next_s    = menu_sel_r;
        cd_next_s     = cd_cnt_r;
        to_next_s     = to_cnt_r;
        reject_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                cd_next_s = {CD_W{1'b0}};
                to_next_s = {TO_W{1'b0}};
                if (ev_ok_s || ev_next_s) begin
                    state_next_s = SELECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SELECT: begin
                cd_next_s = {CD_W{1'b0}};
                if (any_press_s) begin
                    to_next_s = {TO_W{1'b0}};
                end else if (to_cnt_r != TO_LAST) begin
                    to_next_s = to_cnt_r + TO_W'(1);
                end else begin
                    to_next_s = to_cnt_r;
                end
                if (ev_back_s) begin
                    state_next_s = IDLE;
                end else if (ev_ok_s) begin
                    if (ok_allowed_s) begin
                        state_next_s = FIRE;
                    end else begin
                        state_next_s  = SELECT;
                        reject_next_s = 1'b1;
                    end
                end else if (ev_next_s) begin
                    sel_next_s = next_action(menu_sel_r);
                end else if (to_cnt_r == TO_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SELECT;
                end
            end
            FIRE: begin
                state_next_s = COOLDOWN;
                cd_next_s    = {CD_W{1'b0}};
            end
            COOLDOWN: begin
                if (cd_cnt_r == CD_LAST) begin
                    state_next_s = SELECT;
                    cd_next_s    = {CD_W{1'b0}};
                    to_next_s    = {TO_W{1'b0}};
                end else begin
                    cd_next_s = cd_cnt_r + CD_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                cd_next_s    = {CD_W{1'b0}};
                to_next_s    = {TO_W{1'b0}};
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            menu_sel_r  <= 3'd0;
            cd_cnt_r    <= {CD_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            actions_r   <= 8'd0;
            menu_open_r <= 1'b0;
            busy_r      <= 1'b0;
            reject_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            menu_sel_r  <= sel_next_s;
            cd_cnt_r    <= cd_next_s;
            to_cnt_r    <= to_next_s;
            actions_r   <= (state_next_s == FIRE) ? action_onehot(sel_next_s) : 8'd0;
            menu_open_r <= (state_next_s != IDLE);
            busy_r      <= (state_next_s == FIRE) || (state_next_s == COOLDOWN);
            reject_r    <= reject_next_s;
        end
    end

    assign actions   = actions_r;
    assign menu_sel  = menu_sel_r;
    assign menu_open = menu_open_r;
    assign busy      = busy_r;
    assign reject    = reject_r;

endmodule

// File: tb/tb_action_controller.sv
// Directed and randomized bench for action_controller against an event-level
// model of the menu rules; press events are predicted from clean raw edges.
module tb_action_controller;

    localparam int DB   = 4;
    localparam int CD   = 8;
    localparam int TO   = 32;
    localparam int EMIN = 5;
    localparam int LAT  = DB + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic [3:0] energy;
    logic [7:0] actions;
    logic [2:0] menu_sel;
    logic       menu_open, busy, reject;

    action_controller #(
        .DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(CD),
        .IDLE_TIMEOUT(TO), .PLAY_ENERGY_MIN(EMIN)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_next(btn[0]), .btn_ok(btn[1]), .btn_back(btn[2]),
        .energy(energy), .actions(actions), .menu_sel(menu_sel),
        .menu_open(menu_open), .busy(busy), .reject(reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] mask;
    } ev_t;

    ev_t evq[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    // model: 0 closed, 1 browsing, 2 firing, 3 cooling down
    int   m_mode = 0, m_sel = 0, m_cd = 0, m_idle = 0;
    logic m_rej = 1'b0;

    int         cnt_pulse, cnt_busy, cnt_rej;
    logic [7:0] last_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic raise(input logic [2:0] mask);
        ev_t e;
        btn    = btn | mask;
        e.cyc  = cyc + LAT;
        e.mask = mask;
        evq.push_back(e);
    endtask

    task automatic step();
        logic [2:0] ev;
        logic [3:0] e_in;
        logic       r_in, hb, ho, hn;
        logic [7:0] exp_act;
        ev = 3'b000;
        foreach (evq[i]) if (evq[i].cyc == cyc) ev = ev | evq[i].mask;
        while (evq.size() > 0 && evq[0].cyc <= cyc) void'(evq.pop_front());
        e_in = energy;
        r_in = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (r_in) begin
            m_mode = 0; m_sel = 0; m_cd = 0; m_idle = 0; m_rej = 1'b0;
        end else begin
            m_rej = 1'b0;
            hb = ev[2];
            ho = ev[1] && !ev[2];
            hn = ev[0] && !ev[1] && !ev[2];
            case (m_mode)
                0: if (ho || hn) begin m_mode = 1; m_idle = 0; end
                1: begin
                    if (ev != 3'b000) m_idle = 0; else m_idle++;
                    if (hb) m_mode = 0;
                    else if (ho) begin
                        if (m_sel == 4 && int'(e_in) < EMIN) m_rej = 1'b1;
                        else m_mode = 2;
                    end
                    else if (hn) m_sel = (m_sel + 1) % 6;
                    else if (m_idle >= TO) m_mode = 0;
                end
                2: begin m_mode = 3; m_cd = 0; end
                default: begin
                    m_cd++;
                    if (m_cd >= CD) begin m_mode = 1; m_idle = 0; end
                end
            endcase
        end
        exp_act = (m_mode == 2) ? 8'(32'd1 << m_sel) : 8'h00;
        chk("actions", 32'(actions), 32'(exp_act));
        chk("menu_sel", 32'(menu_sel), 32'(m_sel));
        chk("menu_open", 32'(menu_open), 32'(m_mode != 0));
        chk("busy", 32'(busy), 32'(m_mode >= 2));
        chk("reject", 32'(reject), 32'(m_rej));
        chk("onehot", 32'($countones(actions) <= 1), 32'd1);
        if (actions != 8'h00) begin cnt_pulse++; last_act = actions; end
        cnt_busy += int'(busy);
        cnt_rej  += int'(reject);
    endtask

    task automatic clear_counts();
        cnt_pulse = 0; cnt_busy = 0; cnt_rej = 0; last_act = 8'h00;
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int gap);
        raise(mask);
        repeat (hold) step();
        btn = 3'b000;
        repeat (gap) step();
    endtask

    initial begin
        logic [2:0] rmask;
        int         rhold, rgap;

        btn = 3'b000; energy = 4'd0; reset = 1'b1;
        clear_counts();
        repeat (2) step();
        chk("rst_actions", 32'(actions), 32'h0);
        chk("rst_sel", 32'(menu_sel), 32'h0);
        chk("rst_open", 32'(menu_open), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step();

        // open with next: event six cycles after the raw edge, menu opens one edge later
        raise(3'b001);
        repeat (LAT) step();
        chk("lat_pre", 32'(menu_open), 32'h0);
        step();
        chk("lat_open", 32'(menu_open), 32'h1);
        chk("lat_sel", 32'(menu_sel), 32'h0);
        repeat (3) step();
        btn = 3'b000;
        repeat (8) step();

        // confirm action 0
        clear_counts();
        press(3'b010, 10, 10);
        chk("fire_pulses", 32'(cnt_pulse), 32'd1);
        chk("fire_value", 32'(last_act), 32'h01);
        chk("fire_busy_len", 32'(cnt_busy), 32'd9);
        chk("fire_back_sel", 32'(menu_open && !busy), 32'h1);

        // glitchy next never debounces
        repeat (3) begin
            btn[0] = 1'b1; repeat (3) step();
            btn[0] = 1'b0; step();
        end
        repeat (6) step();
        chk("glitch_sel", 32'(menu_sel), 32'h0);

        for (int k = 1; k <= 6; k++) begin
            press(3'b001, 6, 6);
            chk("step_sel", 32'(menu_sel), 32'(k % 6));
        end
        repeat (4) press(3'b001, 6, 6);
        chk("sel_play", 32'(menu_sel), 32'd4);

        // play refused on low energy, accepted at the threshold
        energy = 4'd4;
        clear_counts();
        press(3'b010, 6, 6);
        chk("rej_pulse", 32'(cnt_rej), 32'd1);
        chk("rej_no_act", 32'(cnt_pulse), 32'd0);
        chk("rej_stay", 32'(menu_open && !busy), 32'h1);
        energy = 4'd5;
        clear_counts();
        press(3'b010, 6, 14);
        chk("play_pulses", 32'(cnt_pulse), 32'd1);
        chk("play_value", 32'(last_act), 32'h10);

        // back and ok together: back wins
        clear_counts();
        press(3'b110, 6, 6);
        chk("bo_no_act", 32'(cnt_pulse), 32'd0);
        chk("bo_closed", 32'(menu_open), 32'h0);

        // ok and back arriving during cooldown are discarded
        press(3'b001, 6, 6);
        clear_counts();
        raise(3'b010);
        repeat (4) step();
        btn = 3'b000;
        repeat (4) step();
        raise(3'b110);
        repeat (8) step();
        btn = 3'b000;
        repeat (8) step();
        chk("cd_one_pulse", 32'(cnt_pulse), 32'd1);
        chk("cd_still_open", 32'(menu_open && !busy), 32'h1);

        // idle timeout
        press(3'b100, 6, 6);
        chk("to_closed0", 32'(menu_open), 32'h0);
        raise(3'b001);
        repeat (LAT + 1) step();
        btn = 3'b000;
        repeat (TO - 1) step();
        chk("to_open", 32'(menu_open), 32'h1);
        step();
        chk("to_closed", 32'(menu_open), 32'h0);

        // reset during cooldown
        press(3'b001, 6, 6);
        raise(3'b010);
        repeat (LAT) step();
        btn = 3'b000;
        step();
        chk("rc_fire", 32'(actions), 32'h10);
        step();
        chk("rc_busy", 32'(busy), 32'h1);
        step();
        reset = 1'b1;
        step();
        chk("rc_actions", 32'(actions), 32'h0);
        chk("rc_sel", 32'(menu_sel), 32'h0);
        chk("rc_open", 32'(menu_open), 32'h0);
        chk("rc_busy0", 32'(busy), 32'h0);
        reset = 1'b0;
        clear_counts();
        repeat (10) step();
        chk("rc_no_pulse", 32'(cnt_pulse), 32'd0);

        // randomized clean presses with random energy
        for (int k = 0; k < 60; k++) begin
            rmask = 3'($urandom_range(1, 7));
            rhold = $urandom_range(4, 10);
            rgap  = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(5, 12);
            raise(rmask);
            for (int i = 0; i < rhold; i++) begin
                energy = 4'($urandom_range(0, 15));
                step();
            end
            btn = 3'b000;
            for (int i = 0; i < rgap; i++) begin
                energy = 4'($urandom_range(0, 15));
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
